// File: rtl/ad_chan_sched_pkg.sv
// ad_pkg: shared FSM encoding, defaults and helpers for the ADC channel scheduler.
package ad_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WRAP} state_t;
    localparam int MAX_DWELL_DEF = 6;
    localparam int CH_W = 4;
    function automatic logic [3:0] clamp_dwell(input logic [3:0] d, input int mx);
        return d == 4'd0 ? 4'd1 : (int'(d) > mx ? 4'(mx) : d);
    endfunction
    function automatic logic [3:0] settle_len(input logic [3:0] s);
        return s == 4'd0 ? 4'd1 : s;
    endfunction
endpackage

// File: rtl/ad_chan_sched_if.sv
// ad_chan_sched_if: control, status and averager-result signals of the channel scheduler.
interface ad_chan_sched_if #(parameter int NUM_CH = 8);
    import ad_pkg::*;
    logic start, stop, cont, set_data;
    logic [NUM_CH-1:0] ch_mask;
    logic [3:0] dwell, settle;
    logic [15:0] ad_data;
    logic [CH_W-1:0] cs_now, result_ch;
    logic sample_en, busy, frame_done, err_empty, result_valid;
    logic [11:0] result_data;
    modport master(
        output start, stop, cont, ch_mask, dwell, settle, set_data, ad_data,
        input cs_now, sample_en, busy, frame_done, err_empty, result_valid, result_ch, result_data
    );
    modport slave(
        input start, stop, cont, ch_mask, dwell, settle, set_data, ad_data,
        output cs_now, sample_en, busy, frame_done, err_empty, result_valid, result_ch, result_data
    );
endinterface

// File: rtl/ad_chan_sched_next_ch.sv
// ad_next_ch: finds the next enabled channel above cur and the lowest enabled channel.
module ad_next_ch
    import ad_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   nxt,
    output logic              nxt_vld,
    output logic [CH_W-1:0]   low
);
    // Scanning downward lets the last hit win, giving the lowest qualifying index.
    always_comb begin
        nxt = '0;
        nxt_vld = 1'b0;
        low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) low = CH_W'(i);
            if (mask[i] && i > int'(cur)) begin
                nxt = CH_W'(i);
                nxt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ad_chan_sched.sv
// ad_chan_sched: scans enabled ADC channels with settle blanking and per-channel sample dwell.
module ad_chan_sched
    import ad_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int MAX_DWELL = MAX_DWELL_DEF
) (
    input logic ad_clk,
    input logic rst,
    ad_chan_sched_if.slave bus
);
    state_t state;
    logic [NUM_CH-1:0] sh_mask, srch_mask;
    logic [3:0] sh_dwell, sh_settle, cnt;
    logic stop_pend, nxt_vld, load, restart;
    logic [CH_W-1:0] nxt, low;
    // Lowest channel comes from the live mask, as it is only needed when shadows reload.
    assign srch_mask = (state == IDLE || state == WRAP) ? bus.ch_mask : sh_mask;
    assign load = state == WRAP || (state == IDLE && bus.start && |bus.ch_mask);
    assign restart = bus.cont && !stop_pend && !bus.stop && |bus.ch_mask;
    ad_next_ch #(.NUM_CH(NUM_CH)) u_next (
        .mask(srch_mask), .cur(bus.cs_now), .nxt(nxt), .nxt_vld(nxt_vld), .low(low)
    );
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state <= IDLE;
            bus.cs_now <= '0;
            bus.sample_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err_empty <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_ch <= '0;
            bus.result_data <= '0;
            sh_mask <= '0;
            sh_dwell <= '0;
            sh_settle <= '0;
            cnt <= '0;
            stop_pend <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.err_empty <= 1'b0;
            bus.result_valid <= bus.set_data;
            if (bus.set_data) begin
                bus.result_ch <= bus.ad_data[15:12];
                bus.result_data <= bus.ad_data[11:0];
            end
            if (bus.busy && bus.stop) stop_pend <= 1'b1;
            if (load) begin
                sh_mask <= bus.ch_mask;
                sh_dwell <= clamp_dwell(bus.dwell, MAX_DWELL);
                sh_settle <= settle_len(bus.settle);
            end
            case (state)
                IDLE: if (bus.start) begin
                    if (|bus.ch_mask) begin
                        state <= SETTLE;
                        bus.busy <= 1'b1;
                        bus.cs_now <= low;
                        cnt <= settle_len(bus.settle) - 4'd1;
                    end else bus.err_empty <= 1'b1;
                end
                SETTLE: if (cnt == 4'd0) begin
                    state <= SAMPLE;
                    bus.sample_en <= 1'b1;
                    cnt <= sh_dwell - 4'd1;
                end else cnt <= cnt - 4'd1;
                SAMPLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else if (nxt_vld) begin
                    state <= SETTLE;
                    bus.sample_en <= 1'b0;
                    bus.cs_now <= nxt;
                    cnt <= sh_settle - 4'd1;
                end else begin
                    state <= WRAP;
                    bus.sample_en <= 1'b0;
                    bus.frame_done <= 1'b1;
                end
                WRAP: if (restart) begin
                    state <= SETTLE;
                    bus.cs_now <= low;
                    cnt <= settle_len(bus.settle) - 4'd1;
                end else begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    stop_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad_chan_sched.sv
// tb_ad_chan_sched: directed self-checking bench for the ADC channel scheduler.
module tb_ad_chan_sched;
    import ad_pkg::*;
    logic ad_clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    ad_chan_sched_if #(.NUM_CH(8)) bus();
    ad_chan_sched #(.NUM_CH(8), .MAX_DWELL(6)) dut (.ad_clk(ad_clk), .rst(rst), .bus(bus.slave));
    always #5 ad_clk = ~ad_clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge ad_clk);
        #1;
    endtask
    task automatic now(input string tag, input int cs, input bit se, input bit bz, input bit fd);
        chk({tag, ".cs_now"}, bus.cs_now, cs);
        chk({tag, ".sample_en"}, bus.sample_en, se);
        chk({tag, ".busy"}, bus.busy, bz);
        chk({tag, ".frame_done"}, bus.frame_done, fd);
    endtask
    task automatic cyc(input string tag, input int cs, input bit se, input bit bz, input bit fd);
        step();
        now(tag, cs, se, bz, fd);
    endtask
    task automatic go(input logic [7:0] m, input logic [3:0] d, input logic [3:0] s, input bit c);
        bus.ch_mask = m;
        bus.dwell = d;
        bus.settle = s;
        bus.cont = c;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 0; bus.stop = 0; bus.cont = 0; bus.set_data = 0;
        bus.ch_mask = '0; bus.dwell = '0; bus.settle = '0; bus.ad_data = '0;
        step();
        step();
        now("reset", 0, 0, 0, 0);
        chk("reset.result_valid", bus.result_valid, 0);
        chk("reset.result_data", bus.result_data, 0);
        chk("reset.state", dut.state, IDLE);
        rst = 1'b0;
        // averager results, back to back
        bus.set_data = 1; bus.ad_data = 16'h3ABC;
        step();
        bus.ad_data = 16'h4123;
        chk("res1.valid", bus.result_valid, 1);
        chk("res1.ch", bus.result_ch, 3);
        chk("res1.data", bus.result_data, 12'hABC);
        step();
        bus.set_data = 0;
        chk("res2.valid", bus.result_valid, 1);
        chk("res2.ch", bus.result_ch, 4);
        chk("res2.data", bus.result_data, 12'h123);
        step();
        chk("res3.valid", bus.result_valid, 0);
        // single frame, mask 0x05 dwell 3 settle 2
        go(8'h05, 4'd3, 4'd2, 1'b0);
        now("s1.set0", 0, 0, 1, 0);
        chk("s1.state", dut.state, SETTLE);
        bus.stop = 1'b0;
        cyc("s1.set0", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("s1.smp0", 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) cyc("s1.set2", 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("s1.smp2", 2, 1, 1, 0);
        cyc("s1.wrap", 2, 0, 1, 1);
        cyc("s1.idle", 2, 0, 0, 0);
        // dwell 0 -> 1 sample, settle 0 -> 1 blanking cycle
        go(8'h01, 4'd0, 4'd0, 1'b0);
        now("c0.set", 0, 0, 1, 0);
        cyc("c0.smp", 0, 1, 1, 0);
        cyc("c0.wrap", 0, 0, 1, 1);
        cyc("c0.idle", 0, 0, 0, 0);
        // dwell 9 -> 6; mid-frame dwell change must be ignored
        go(8'h01, 4'd9, 4'd0, 1'b0);
        bus.dwell = 4'd1;
        now("c9.set", 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc("c9.smp", 0, 1, 1, 0);
        cyc("c9.wrap", 0, 0, 1, 1);
        cyc("c9.idle", 0, 0, 0, 0);
        // continuous restarts on wrap, then stops after a stop request
        go(8'h02, 4'd1, 4'd1, 1'b1);
        now("cw.set", 1, 0, 1, 0);
        cyc("cw.smp", 1, 1, 1, 0);
        cyc("cw.wrap", 1, 0, 1, 1);
        cyc("cw.reset", 1, 0, 1, 0);
        bus.stop = 1'b1;
        cyc("cw.smp2", 1, 1, 1, 0);
        bus.stop = 1'b0;
        cyc("cw.wrap2", 1, 0, 1, 1);
        cyc("cw.idle", 1, 0, 0, 0);
        // mask 0x81 continuous, stop during channel 0 sample
        go(8'h81, 4'd2, 4'd1, 1'b1);
        now("st.set0", 0, 0, 1, 0);
        cyc("st.smp0a", 0, 1, 1, 0);
        bus.stop = 1'b1;
        cyc("st.smp0b", 0, 1, 1, 0);
        bus.stop = 1'b0;
        cyc("st.set7", 7, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc("st.smp7", 7, 1, 1, 0);
        cyc("st.wrap", 7, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc("st.idle", 7, 0, 0, 0);
        chk("st.state", dut.state, IDLE);
        // reset mid-scan on channel 2 sample
        go(8'hFF, 4'd3, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        cyc("rs.set1", 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step();
        cyc("rs.smp2", 2, 1, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        now("rs.abort", 0, 0, 0, 0);
        chk("rs.state", dut.state, IDLE);
        cyc("rs.after", 0, 0, 0, 0);
        // empty mask start
        bus.ch_mask = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("em.err", bus.err_empty, 1);
        now("em.pulse", 0, 0, 0, 0);
        step();
        chk("em.err_clr", bus.err_empty, 0);
        now("em.after", 0, 0, 0, 0);
        chk("em.state", dut.state, IDLE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_chan_sched.md
AD_CHAN_SCHED -- requirements
Module: ad_chan_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, giving the number of selectable analog channels (1..16).
REQ-002 The block SHALL have parameter MAX_DWELL, default 6, giving the maximum samples per channel the downstream averager accepts.
REQ-003 The block SHALL have a single clock and a reset: ad_clk drives all logic, and rst is synchronous and active-high.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- ad_clk  in  1  ADC sample clock
- rst  in  1  synchronous active-high reset
- start  in  1  level, sampled each cycle; begins a scan from IDLE
- stop  in  1  level, sampled each cycle; requests end of scan
- cont  in  1  1 = continuous frames, 0 = single frame
- ch_mask  in  NUM_CH  enabled channels
- dwell  in  4  samples per channel
- settle  in  4  blanking cycles after each channel switch
- set_data  in  1  averager result strobe
- ad_data  in  16  averager result {ch[3:0], avg[11:0]}
- cs_now  out  4  channel select to mux and averager
- sample_en  out  1  high during valid sampling cycles
- busy  out  1  scan in progress
- frame_done  out  1  one-cycle pulse at the end of each frame
- err_empty  out  1  one-cycle pulse when start is accepted with an all-zero mask
- result_valid  out  1  one-cycle result strobe
- result_ch  out  4  channel of the result
- result_data  out  12  averaged value of the result

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and WRAP, and all outputs SHALL be registered.
REQ-006 The block SHALL copy ch_mask, dwell and settle into shadow registers on an accepted start and at each frame boundary; mid-frame input changes SHALL have no effect.
REQ-007 The block SHALL clamp dwell as follows: shadow dwell = 1 if dwell is 0; = MAX_DWELL if dwell > MAX_DWELL; otherwise dwell.
REQ-008 The block SHALL set the settle length to max(settle,1) cycles.
REQ-009 On start=1 in IDLE with a nonzero mask, the next cycle SHALL have: state = SETTLE, busy = 1, cs_now = lowest enabled channel index.
REQ-010 On start=1 in IDLE with mask 0, the block SHALL pulse err_empty for one cycle and remain in IDLE.
REQ-011 When start=1 and state is not IDLE, the block SHALL ignore start.
REQ-012 The block SHALL hold SETTLE for max(settle,1) cycles with sample_en = 0, then move to SAMPLE.
REQ-013 The block SHALL hold SAMPLE for exactly the shadow dwell cycles with sample_en = 1.
REQ-014 At the last SAMPLE cycle, if a higher enabled channel exists, the block SHALL go to SETTLE with cs_now = next higher enabled channel.
REQ-015 At the last SAMPLE cycle, if no higher enabled channel exists, the block SHALL go to WRAP.
REQ-016 WRAP SHALL last one cycle, during which the block SHALL:
- pulse frame_done;
- reload the shadow registers;
- go to SETTLE on the lowest enabled channel if cont = 1, stop is not pending and the reloaded mask is nonzero;
- otherwise go to IDLE with busy = 0.
REQ-017 A stop of 1 while busy SHALL set a pending flag; the current channel SHALL finish its full dwell and the scan SHALL end at the next WRAP.
REQ-018 The pending stop flag SHALL be cleared on entering IDLE.
REQ-019 A stop while in IDLE SHALL have no effect.
REQ-020 When cs_now changes, it SHALL change only on entry to SETTLE, and SHALL hold its value in SAMPLE, WRAP and IDLE.
REQ-021 On set_data = 1, the block SHALL, one cycle later, pulse result_valid and register result_ch = ad_data[15:12] and result_data = ad_data[11:0].
REQ-022 The block SHALL pass set_data through independent of state, including in IDLE for the final-channel flush.
REQ-023 Back-to-back set_data pulses SHALL each produce a result_valid pulse, with no drop.

Reset
REQ-024 While rst = 1 at a rising ad_clk edge, the block SHALL force:
- state = IDLE;
- cs_now = 0;
- sample_en, busy, frame_done, err_empty and result_valid = 0;
- result_ch = 0 and result_data = 0;
- shadow registers, counters and pending stop flag = 0.
REQ-025 A reset asserted mid-scan SHALL abort the scan immediately, with no frame_done pulse.

Structure
REQ-026 A shared package ad_pkg SHALL hold the FSM state encoding, the MAX_DWELL default and the width of the ad_data channel-tag field.
REQ-027 A combinational sub-module ad_next_ch SHALL perform the next-enabled-channel search, returning next index, valid and lowest index from the mask and current index.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Single frame: mask=0x05, dwell=3, settle=2, cont=0, start pulse -> cs_now 0 for 5 cycles with sample_en high on the last 3, then cs_now 2 for 5 cycles, then one frame_done, busy falls the cycle after WRAP.
- Clamping: dwell=0 gives 1 sample cycle per channel; dwell=9 gives 6; settle=0 gives 1 blanking cycle.
- Continuous with stop: mask=0x81, cont=1, stop asserted during channel 0 SAMPLE -> channel 0 and channel 7 both complete full dwell, frame_done once, then IDLE; no further cs_now change.
- Empty mask: mask=0, start -> err_empty pulses for 1 cycle, busy stays 0, cs_now stays 0.
- Results: set_data pulses on 2 consecutive cycles with ad_data 0x3ABC then 0x4123 -> result_valid 2 consecutive cycles one cycle later, result_ch/result_data 3/0xABC then 4/0x123.
- Reset mid-scan: rst during channel 2 SAMPLE with mask=0xFF -> next cycle state IDLE, cs_now=0, busy=0, no frame_done.
